// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 receiver that turns printable make codes into ASCII for the VGA text path.
// Define PS2_SHIFT_EN to track left/right shift and emit lowercase letters while no shift is held.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2520
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic [7:0] oKeyboardInput,
    output logic       oAdvanceCursor,
    output logic       oFrameError
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Scan code to uppercase ASCII; 0 means the code has no printable mapping.
    function automatic logic [7:0] lookup(input logic [7:0] code);
        case (code)
            8'h1C: lookup = 8'h41;  8'h32: lookup = 8'h42;  8'h21: lookup = 8'h43;
            8'h23: lookup = 8'h44;  8'h24: lookup = 8'h45;  8'h2B: lookup = 8'h46;
            8'h34: lookup = 8'h47;  8'h33: lookup = 8'h48;  8'h43: lookup = 8'h49;
            8'h3B: lookup = 8'h4A;  8'h42: lookup = 8'h4B;  8'h4B: lookup = 8'h4C;
            8'h3A: lookup = 8'h4D;  8'h31: lookup = 8'h4E;  8'h44: lookup = 8'h4F;
            8'h4D: lookup = 8'h50;  8'h15: lookup = 8'h51;  8'h2D: lookup = 8'h52;
            8'h1B: lookup = 8'h53;  8'h2C: lookup = 8'h54;  8'h3C: lookup = 8'h55;
            8'h2A: lookup = 8'h56;  8'h1D: lookup = 8'h57;  8'h22: lookup = 8'h58;
            8'h35: lookup = 8'h59;  8'h1A: lookup = 8'h5A;
            8'h45: lookup = 8'h30;  8'h16: lookup = 8'h31;  8'h1E: lookup = 8'h32;
            8'h26: lookup = 8'h33;  8'h25: lookup = 8'h34;  8'h2E: lookup = 8'h35;
            8'h36: lookup = 8'h36;  8'h3D: lookup = 8'h37;  8'h3E: lookup = 8'h38;
            8'h46: lookup = 8'h39;
            8'h29: lookup = 8'h20;  8'h5A: lookup = 8'h0D;  8'h66: lookup = 8'h08;
            default: lookup = 8'h00;
        endcase
    endfunction

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt, fall;
    logic [FW-1:0] fcnt;

    // NOTE: non-blocking assignments in every clocked block keep the two flops of
    // each synchronizer as separate stages instead of collapsing them into one.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            // Preset to the idle-high bus level so reset release is not seen as a falling edge.
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            filt   <= 1'b1;
            fcnt   <= '0;
            fall   <= 1'b0;
        end else begin
            clk_s1 <= iPS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= iPS2_DAT;
            dat_s2 <= dat_s1;
            fall   <= 1'b0;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_s2;
                fcnt <= '0;
                fall <= ~clk_s2;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity, ext, brk;
    logic [TW-1:0] tcnt;
    logic [7:0]    ascii, ascii_out;
    logic          frame_ok, timeout;

    assign ascii    = lookup(shreg);
    assign frame_ok = dat_s2 && (^{shreg, parity});
    assign timeout  = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_SHIFT_EN
    logic shift_l, shift_r;
    assign ascii_out = (ascii >= 8'h41 && ascii <= 8'h5A && !(shift_l || shift_r))
                       ? ascii + 8'h20 : ascii;
`else
    assign ascii_out = ascii;
`endif

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shreg          <= '0;
            parity         <= 1'b0;
            tcnt           <= '0;
            ext            <= 1'b0;
            brk            <= 1'b0;
`ifdef PS2_SHIFT_EN
            shift_l        <= 1'b0;
            shift_r        <= 1'b0;
`endif
            oKeyboardInput <= '0;
            oAdvanceCursor <= 1'b0;
            oFrameError    <= 1'b0;
        end else begin
            oAdvanceCursor <= 1'b0;
            oFrameError    <= 1'b0;
            tcnt           <= (state == IDLE || fall) ? '0 : tcnt + TW'(1);
            // A timeout has priority over a coincident fall, which is then dropped.
            if (timeout) begin
                state       <= IDLE;
                oFrameError <= 1'b1;
                ext         <= 1'b0;
                brk         <= 1'b0;
            end else if (fall) begin
                case (state)
                    IDLE: if (!dat_s2) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity <= dat_s2;
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            oFrameError <= 1'b1;
                            ext         <= 1'b0;
                            brk         <= 1'b0;
                        end else if (shreg == 8'hE0) begin
                            ext <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk <= 1'b1;
                        end else begin
                            ext <= 1'b0;
                            brk <= 1'b0;
                            if (!ext) begin
`ifdef PS2_SHIFT_EN
                                if (shreg == 8'h12) shift_l <= ~brk;
                                else if (shreg == 8'h59) shift_r <= ~brk;
                                else
`endif
                                if (!brk && ascii != 8'h00) begin
                                    oKeyboardInput <= ascii_out;
                                    oAdvanceCursor <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus random frames against a table model.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] kb;
    logic       adv, ferr;

    always #5 clk = ~clk;

    ps2_key_decoder dut (
        .iVGA_CLK      (clk),
        .iRST          (rst),
        .iPS2_CLK      (ps2_clk),
        .iPS2_DAT      (ps2_dat),
        .oKeyboardInput(kb),
        .oAdvanceCursor(adv),
        .oFrameError   (ferr)
    );

    int passed = 0;
    int total  = 0;

    // Strobe monitor: counts strobes and flags width, overlap and unannounced output changes.
    int         adv_cnt = 0, err_cnt = 0, shape_viol = 0;
    logic       prev_adv = 1'b0, prev_err = 1'b0;
    logic [7:0] prev_kb = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_adv = 1'b0;
            prev_err = 1'b0;
            prev_kb  = kb;
        end else begin
            if (adv) adv_cnt++;
            if (ferr) err_cnt++;
            if ((adv && prev_adv) || (ferr && prev_err) || (adv && ferr) || (kb !== prev_kb && !adv))
                shape_viol++;
            prev_adv = adv;
            prev_err = ferr;
            prev_kb  = kb;
        end
    end

    // Reference model: scan-code table plus key-state flags.
    logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] asc_tab[256];
    bit         valid_tab[256];
    bit         letter_tab[256];
    bit         m_ext, m_brk, m_lsh, m_rsh;
    logic [7:0] m_char;

    task automatic init_model();
        for (int i = 0; i < 256; i++) begin
            asc_tab[i] = 8'h00; valid_tab[i] = 1'b0; letter_tab[i] = 1'b0;
        end
        for (int i = 0; i < 26; i++) begin
            asc_tab[letter_codes[i]] = 8'h41 + 8'(i);
            valid_tab[letter_codes[i]] = 1'b1;
            letter_tab[letter_codes[i]] = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            asc_tab[digit_codes[i]] = 8'h30 + 8'(i);
            valid_tab[digit_codes[i]] = 1'b1;
        end
        asc_tab[8'h29] = 8'h20; valid_tab[8'h29] = 1'b1;
        asc_tab[8'h5A] = 8'h0D; valid_tab[8'h5A] = 1'b1;
        asc_tab[8'h66] = 8'h08; valid_tab[8'h66] = 1'b1;
        m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_char = 8'h00;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad, output int e_adv, output int e_err);
        e_adv = 0;
        e_err = 0;
        if (bad) begin
            e_err = 1; m_ext = 0; m_brk = 0;
            return;
        end
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (!m_ext) begin
`ifdef PS2_SHIFT_EN
                if (b == 8'h12) m_lsh = !m_brk;
                else if (b == 8'h59) m_rsh = !m_brk;
                else
`endif
                if (!m_brk && valid_tab[b]) begin
                    e_adv  = 1;
                    m_char = asc_tab[b];
`ifdef PS2_SHIFT_EN
                    if (letter_tab[b] && !m_lsh && !m_rsh) m_char = asc_tab[b] + 8'h20;
`endif
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_dat = bits[i];
            repeat (8) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (12) @(negedge clk);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             output int o_adv, output int o_err);
        int a0, e0;
        a0 = adv_cnt;
        e0 = err_cnt;
        send_bits(frame_bits(b, bad_par, bad_stop), 11);
        repeat (20) @(negedge clk);
        o_adv = adv_cnt - a0;
        o_err = err_cnt - e0;
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        total++;
        if (kb !== 8'h00 || adv !== 1'b0 || ferr !== 1'b0)
            $display("FAIL reset_held: kb=%h adv=%b err=%b, want 00/0/0", kb, adv, ferr);
        else passed++;
        rst = 1'b0;
        repeat (50) @(negedge clk);
        total++;
        if (kb !== 8'h00 || adv_cnt !== 0 || err_cnt !== 0)
            $display("FAIL reset_release: kb=%h adv_cnt=%0d err_cnt=%0d, want 00/0/0", kb, adv_cnt, err_cnt);
        else passed++;
    endtask

    // Runs a directed code table; bad[i] bit0 = bad parity, bit1 = bad stop.
    task automatic test_table(input string name, input logic [7:0] codes[$], input logic [1:0] bad[$]);
        int a, e, ea, ee;
        foreach (codes[i]) begin
            run_frame(codes[i], bad[i][0], bad[i][1], a, e);
            model_frame(codes[i], |bad[i], ea, ee);
            total++;
            if (a !== ea || e !== ee || kb !== m_char)
                $display("FAIL %s[%0d] code=%h: strobes=%0d errors=%0d kb=%h, want %0d/%0d/%h",
                         name, i, codes[i], a, e, kb, ea, ee, m_char);
            else passed++;
        end
    endtask

    task automatic test_valid_key();
        test_table("valid_key", '{8'h1C}, '{2'b00});
        total++;
        if (kb !== 8'h41 && kb !== 8'h61)
            $display("FAIL valid_key_ascii: kb=%h, want 41 or 61", kb);
        else passed++;
    endtask

    task automatic test_break();
        test_table("break", '{8'hF0, 8'h1C, 8'h32}, '{2'b00, 2'b00, 2'b00});
    endtask

    task automatic test_extended();
        test_table("extended", '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h29},
                   '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        total++;
        if (kb !== 8'h20) $display("FAIL extended_space: kb=%h, want 20", kb);
        else passed++;
    endtask

    task automatic test_framing_errors();
        test_table("framing", '{8'h1C, 8'h1C, 8'hF0, 8'h16}, '{2'b01, 2'b10, 2'b01, 2'b00});
    endtask

    task automatic test_timeout();
        int a0, e0, a, e, ea, ee;
        a0 = adv_cnt;
        e0 = err_cnt;
        send_bits(frame_bits(8'h1C, 0, 0), 5);
        repeat (2700) @(negedge clk);
        m_ext = 0;
        m_brk = 0;
        total++;
        if (err_cnt - e0 !== 1 || adv_cnt - a0 !== 0)
            $display("FAIL timeout: errors=%0d strobes=%0d, want 1/0", err_cnt - e0, adv_cnt - a0);
        else passed++;
        run_frame(8'h45, 0, 0, a, e);
        model_frame(8'h45, 0, ea, ee);
        total++;
        if (a !== 1 || e !== 0 || kb !== 8'h30)
            $display("FAIL timeout_recover: strobes=%0d errors=%0d kb=%h, want 1/0/30", a, e, kb);
        else passed++;
    endtask

    task automatic test_glitch();
        int a0, e0;
        a0 = adv_cnt;
        e0 = err_cnt;
        @(negedge clk) ps2_dat = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        ps2_dat = 1'b1;
        repeat (2700) @(negedge clk);
        total++;
        if (err_cnt - e0 !== 0 || adv_cnt - a0 !== 0)
            $display("FAIL glitch: errors=%0d strobes=%0d, want 0/0", err_cnt - e0, adv_cnt - a0);
        else passed++;
        test_table("after_glitch", '{8'h1C}, '{2'b00});
    endtask

    task automatic test_reset_midframe();
        int e0;
        send_bits(frame_bits(8'h66, 0, 0), 6);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_char = 8'h00;
        e0 = err_cnt;
        repeat (2700) @(negedge clk);
        total++;
        if (err_cnt - e0 !== 0 || kb !== 8'h00)
            $display("FAIL reset_midframe: errors=%0d kb=%h, want 0/00", err_cnt - e0, kb);
        else passed++;
        test_table("after_reset", '{8'h29}, '{2'b00});
    endtask

`ifdef PS2_SHIFT_EN
    task automatic test_shift();
        test_table("shift", '{8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C, 8'h59, 8'h32, 8'hF0, 8'h59, 8'h32},
                   '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00});
        total++;
        if (kb !== 8'h62) $display("FAIL shift_final: kb=%h, want 62", kb);
        else passed++;
    endtask
`endif

    task automatic test_random();
        logic [7:0] codes[$];
        logic [1:0] bad[$];
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: codes.push_back(letter_codes[$urandom_range(0, 25)]);
                3:       codes.push_back(digit_codes[$urandom_range(0, 9)]);
                4:       codes.push_back($urandom_range(0, 1) ? 8'hF0 : 8'hE0);
                5:       codes.push_back($urandom_range(0, 1) ? 8'h12 : 8'h59);
                default: codes.push_back(8'($urandom_range(0, 255)));
            endcase
            bad.push_back(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'b00);
        end
        test_table("random", codes, bad);
    endtask

    task automatic test_strobe_shape();
        total++;
        if (shape_viol !== 0) $display("FAIL strobe_shape: violations=%0d, want 0", shape_viol);
        else passed++;
    endtask

    initial begin
        init_model();
        test_reset();
        test_valid_key();
        test_break();
        test_extended();
        test_framing_errors();
        test_timeout();
        test_glitch();
`ifdef PS2_SHIFT_EN
        test_shift();
`endif
        test_random();
        test_reset_midframe();
        test_strobe_shape();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 scan-code set 2 frames from the keyboard pins and converts printable make codes to 8-bit ASCII for the VGA text/cursor path. It sits directly upstream of the VGA controller. Its outputs drive the controller's `KeyboardInput[7:0]` and `AdvanceCursor` inputs. It runs entirely in the pixel clock domain.

## Interface
- `FILTER_LEN`, default 4: consecutive identical synchronized samples required before the PS/2 clock level is accepted.
- `TIMEOUT_CYCLES`, default 2520: idle clock cycles allowed between PS/2 clock falling edges inside a frame (100 µs at 25.2 MHz).
- `iVGA_CLK`  in  1  pixel clock; the only clock.
- `iRST`  in  1  asynchronous, active-high reset.
- `iPS2_CLK`  in  1  raw PS/2 clock pin (asynchronous).
- `iPS2_DAT`  in  1  raw PS/2 data pin (asynchronous).
- `oKeyboardInput`  out  8  last decoded ASCII character; held until the next valid key.
- `oAdvanceCursor`  out  1  one-cycle strobe; marks a new character on `oKeyboardInput`.
- `oFrameError`  out  1  one-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- **Input conditioning**
  - Both pins pass through a 2-flop synchronizer.
  - PS/2 clock goes through a glitch filter: the filtered level changes only after `FILTER_LEN` equal samples.
  - A falling edge of the filtered clock produces `fall`, a one-cycle pulse. Data is sampled (synchronized) on `fall`.
- **Frame FSM**
  - Frame format: start (0), 8 data bits LSB-first, odd parity, stop (1).
  - IDLE: on `fall` with data=0 → DATA, bit count=0. On `fall` with data=1, stay in IDLE and raise no error.
  - DATA: shift data in on each `fall`. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: on `fall`, the frame is accepted only if stop=1 and (data ^ parity) reduction-XOR = 1. Otherwise pulse `oFrameError`. Either way → IDLE.
  - Timeout: a counter clears on every `fall`. If it reaches `TIMEOUT_CYCLES` in any state other than IDLE, pulse `oFrameError` and → IDLE.
- **Code layer** (runs on accepted bytes only)
  - `E0` sets the ext flag. `F0` sets the brk flag.
  - Any other byte is handled as follows, then both flags clear:
    - if ext is set, ignore the byte;
    - else if brk is set, treat it as a break (release) code;
    - else treat it as a make code.
  - Any error (parity, stop or timeout) also clears ext and brk.
  - A make code found in the table below sets `oKeyboardInput` and pulses `oAdvanceCursor`. An unmapped make code produces no output change.
  - Typematic repeats are ordinary make codes, so each one produces a strobe.
- **Table** (scan code → ASCII, uppercase)
  - Letters: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A.
  - Digits: 0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46.
  - Others: space 29→20h, enter 5A→0Dh, backspace 66→08h.

## Timing
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - ext, brk, shift flags clear;
  - timeout counter and shift register 0;
  - synchronizers and filter preset to 1 (bus idle).
- Latency: the `fall` pulse occurs 2 (sync) + `FILTER_LEN` cycles after the raw falling edge.
- Decode and output: `oKeyboardInput` and `oAdvanceCursor` change together, in the cycle after the stop-bit `fall` cycle.
- `oFrameError` is asserted in that same relative cycle for stop/parity errors, and in the cycle the counter hits the limit for a timeout.
- Strobes are exactly one cycle wide and never overlap each other.
- Reset asserted mid-frame: the partial frame is discarded and there is no error strobe after release.
- A `fall` arriving in the same cycle as a timeout: the timeout wins, and the FSM restarts in IDLE evaluating that `fall` on the next edge only.

## Configuration
- `PS2_SHIFT_EN` defined:
  - track left shift (12h) and right shift (59h): set on make, clear on break;
  - letters output lowercase (ASCII + 20h) while neither shift is held, and uppercase while either is held;
  - shift make codes produce no strobe.
- `PS2_SHIFT_EN` undefined:
  - no shift state exists;
  - letters are always uppercase;
  - 12h and 59h are unmapped.

## Test plan
- **Valid key:** frame 1Ch (parity 0, stop 1) → `oKeyboardInput`=41h and a single one-cycle `oAdvanceCursor` strobe; `oFrameError` stays 0.
- **Break sequence:** F0h then 1Ch → no strobe, `oKeyboardInput` keeps its previous value. A following 32h → 42h with a strobe.
- **Extended code:** E0h, 75h, then E0h, F0h, 75h → no strobes. A following 29h → 20h with a strobe.
- **Framing errors:**
  - 1Ch with parity bit 1 → `oFrameError` pulse, no strobe;
  - 1Ch with stop bit 0 → `oFrameError` pulse, no strobe.
- **Timeout:** PS/2 clock stops after 4 data bits for ≥ `TIMEOUT_CYCLES` → one `oFrameError` pulse. A complete 45h frame afterwards → 30h with a strobe.
- **Shift (with `PS2_SHIFT_EN`):**
  - 1Ch → 61h;
  - 12h, 1Ch → 41h;
  - F0h, 12h, 1Ch → 61h.
- **Glitch rejection:** a 2-cycle low glitch on the PS/2 clock while in IDLE → no FSM transition and no error.
